// File: rtl/disp_src_sched_if.sv
// rtl/disp_src_sched_if.sv - source request/data and display bus shared by debug taps, scheduler and display driver
interface disp_src_sched_if #(parameter int NSRC = 4);
  localparam int ID_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]      req;
  logic [32*NSRC-1:0]   data;
  logic [NSRC-1:0]      grant;
  logic [ID_W-1:0]      src_id;
  logic [31:0]          register;
  logic                 disp_valid;

  modport master (output req, data, input grant, src_id, register, disp_valid);
  modport slave  (input req, data, output grant, src_id, register, disp_valid);
endinterface

// File: rtl/disp_src_sched.sv
// rtl/disp_src_sched.sv - round-robin scheduler sharing the 7-seg display between debug sources
// Optional freeze input enabled by DISP_SCHED_FREEZE_EN.
module disp_src_sched #(
  parameter int NSRC  = 4,
  parameter int DWELL = 100000000,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic manual,
  input  logic step,
`ifdef DISP_SCHED_FREEZE_EN
  input  logic freeze,
`endif
  disp_src_sched_if.slave bus
);
  localparam int ID_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   src_id, src_nxt, win_id;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [31:0]       register;
  logic              step_q, manual_q;
  logic              win_found, step_rise, owner_drop, expired, advance, hold, load_reg;

`ifdef DISP_SCHED_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  // Search starts just after the current owner so it only wins as the sole requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = src_id;
    for (int k = 1; k <= NSRC; k++) begin
      if (!win_found && bus.req[(int'(src_id) + k) % NSRC]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(src_id) + k) % NSRC);
      end
    end
  end

  always_comb begin
    step_rise  = step & ~step_q;
    owner_drop = ~bus.req[src_id];
    expired    = ~manual & (count == CNT_W'(DWELL - 1));
    advance    = (state == SHOW) & ~hold & (step_rise | expired | owner_drop);
    state_nxt  = state;
    src_nxt    = src_id;
    count_nxt  = count;
    load_reg   = 1'b0;
    case (state)
      IDLE: begin
        if (!hold && win_found) begin
          state_nxt = SHOW;
          src_nxt   = win_id;
          count_nxt = '0;
        end
      end
      SHOW: begin
        load_reg = ~hold;
        if (advance) begin
          count_nxt = '0;
          if (win_found) src_nxt = win_id;
          else           state_nxt = IDLE;
        end else if (manual != manual_q) begin
          count_nxt = '0;
        end else if (hold) begin
          count_nxt = count;
        end else if (manual) begin
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_id   <= '0;
      count    <= '0;
      register <= 32'h0;
      step_q   <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      src_id   <= src_nxt;
      count    <= count_nxt;
      step_q   <= step;
      manual_q <= manual;
      if (load_reg) register <= bus.data[int'(src_id)*32 +: 32];
    end
  end

  assign bus.grant      = (state == SHOW) ? (NSRC'(1) << src_id) : '0;
  assign bus.src_id     = src_id;
  assign bus.register   = register;
  assign bus.disp_valid = (state == SHOW);
endmodule
